bus_scheduler: RTL
==================

Name: bus_scheduler

Overview:
- Two-master, three-slave system-bus scheduler; replaces the fixed-priority grant path with round-robin arbitration, per-slave readiness gating, transaction tracking and timeout recovery.
- Sits between master request/slave-select lines and the bus mux/demux; drives bus_grant/slave_grant select codes and per-master grants.
- The bus is owned by one master until transaction_done, request drop or timeout.

Parameters:
- TIMEOUT_CYCLES, 64, max HOLD cycles before forced release; legal 2..65535; counter width 16 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- m1_request  input  1  master 1 requests bus
- m2_request  input  1  master 2 requests bus
- m1_slave_select  input  2  master 1 target: 01/10/11 = slave 1/2/3; 00 = none (request ignored)
- m2_slave_select  input  2  master 2 target, same coding
- slave_ready  input  3  bit i-1 high = slave i can accept a transaction
- transaction_done  input  1  one-cycle pulse from bus: current transfer complete
- m1_grant  output  1  master 1 owns bus
- m2_grant  output  1  master 2 owns bus
- busy  output  1  bus allocated or in turnaround
- bus_grant  output  2  00 none, 01 master 1, 10 master 2
- slave_grant  output  2  captured target slave code; 00 when none
- timeout  output  1  one-cycle pulse: transaction aborted by timeout

Behaviour:
- All outputs registered. While reset = 0: state IDLE, all outputs 0, last_owner = master 2, counter = 0. Applies asynchronously, including mid-transaction.
- Eligibility: master k is eligible when mk_request = 1, mk_slave_select != 00, and slave_ready[select-1] = 1.
- States: IDLE, HOLD, RELEASE.
- IDLE:
  - No eligible master: stay in IDLE.
  - One eligible master: grant it.
  - Both eligible: grant the master that is not last_owner.
  - On a grant, the next state is HOLD. The winner's slave_select is captured into slave_grant, bus_grant and mX_grant are set, busy = 1, counter = 0.
  - Latency: request sampled at edge N; grant is visible after edge N.
- HOLD:
  - Grants are held stable. slave_select changes are ignored. counter increments each cycle.
  - transaction_done = 1: go to RELEASE.
  - Owner's request = 0 (and done = 0): go to RELEASE (abandon).
  - counter = TIMEOUT_CYCLES-1 with done = 0: go to RELEASE and assert timeout = 1 during the RELEASE cycle.
  - done and the timeout condition in the same cycle: done wins, timeout stays 0.
  - The other master's request never preempts the owner.
- RELEASE (exactly one cycle):
  - m1_grant, m2_grant, bus_grant and slave_grant are 0; busy = 1 (turnaround).
  - last_owner is updated to the released master. Next state is IDLE.
  - timeout is 0 except in the timeout case.
- busy = 1 in HOLD and RELEASE, 0 in IDLE.
- Back-to-back: done sampled at edge k leads to RELEASE after k, IDLE after k+1, earliest new grant visible after k+2.
- slave_ready is checked only at arbitration. A drop during HOLD has no effect.
- At most one of m1_grant and m2_grant is high, and only in HOLD. bus_grant always agrees with mX_grant.

Test Plan:
- Reset, then m1_request = 1, m1_slave_select = 10, slave_ready = 111 -> one edge later m1_grant = 1, bus_grant = 01, slave_grant = 10, busy = 1. Assert reset = 0 mid-HOLD -> all outputs 0 immediately, without a clock edge.
- Both requests high continuously, selects 01/11, done pulsed 3 cycles after each grant -> grants alternate m1, m2, m1, m2, with a 1-cycle RELEASE (busy = 1, bus_grant = 00) and 1 IDLE cycle between each.
- m2_request = 1 with m2_slave_select = 11 and slave_ready = 011 -> no grant while slave 3 is not ready. Set slave_ready[2] = 1 -> m2_grant one edge later. m1 with select 00 is never granted.
- TIMEOUT_CYCLES = 4, m1 granted, no done -> after 4 HOLD cycles, RELEASE with timeout = 1 for exactly one cycle. Repeat with done on the 4th HOLD cycle -> timeout stays 0.
- m1 granted, then m1_request drops at HOLD cycle 2 while m2 is requesting -> RELEASE, then m2 granted two edges after the drop, with last_owner = m1.
- During HOLD, toggle the owner's slave_select and the other master's request -> slave_grant and the grants stay unchanged until RELEASE.

Source files
------------

// File: rtl/bus_scheduler.sv
// ---------------------------------------------------------------------------
// bus_scheduler
//
// Two-master, three-slave system-bus scheduler. Masters are arbitrated
// round-robin, a request is considered only when its target slave is ready,
// and the winner keeps the bus until the transfer completes, the owner drops
// its request, or a hold timeout forces the bus free. Every release passes
// through a single turnaround cycle before the next arbitration.
//
// Ports
//   clk               system clock, rising-edge active
//   reset             asynchronous active-low reset (0 = reset)
//   m1_request        master 1 requests the bus
//   m2_request        master 2 requests the bus
//   m1_slave_select   master 1 target: 01/10/11 = slave 1/2/3, 00 = none
//   m2_slave_select   master 2 target, same coding
//   slave_ready       bit i-1 high = slave i can accept a transaction
//   transaction_done  one-cycle pulse: current transfer complete
//   m1_grant          master 1 owns the bus
//   m2_grant          master 2 owns the bus
//   busy              bus allocated or in turnaround
//   bus_grant         00 none, 01 master 1, 10 master 2
//   slave_grant       captured target slave code, 00 when none
//   timeout           one-cycle pulse: transaction aborted by timeout
// ---------------------------------------------------------------------------
module bus_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m1_request,
   input  logic       m2_request,
   input  logic [1:0] m1_slave_select,
   input  logic [1:0] m2_slave_select,
   input  logic [2:0] slave_ready,
   input  logic       transaction_done,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic       busy,
   output logic [1:0] bus_grant,
   output logic [1:0] slave_grant,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Counter value reached on the last permitted HOLD cycle.
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;          // 0 = master 1, 1 = master 2
   logic        lastOwner_q, lastOwner_d;  // 0 = master 1, 1 = master 2
   logic [15:0] counter_q, counter_d;
   logic        m1Grant_q, m1Grant_d;
   logic        m2Grant_q, m2Grant_d;
   logic        busy_q, busy_d;
   logic [1:0]  busGrant_q, busGrant_d;
   logic [1:0]  slaveGrant_q, slaveGrant_d;
   logic        timeout_q, timeout_d;

   logic        m1Eligible;
   logic        m2Eligible;
   logic        winnerM2;
   logic        ownerRequest;

   // A select code of 00 never matches a slave, so it is never ready.
   function automatic logic targetReady(input logic [1:0] sel, input logic [2:0] rdy);
      logic r;
      unique case (sel)
         2'b01:   r = rdy[0];
         2'b10:   r = rdy[1];
         2'b11:   r = rdy[2];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Eligibility and round-robin winner. On a tie the master that did not
   // own the bus last time wins.
   always_comb begin
      m1Eligible   = m1_request && targetReady(m1_slave_select, slave_ready);
      m2Eligible   = m2_request && targetReady(m2_slave_select, slave_ready);
      winnerM2     = m2Eligible && (!m1Eligible || !lastOwner_q);
      ownerRequest = owner_q ? m2_request : m1_request;
   end

   // Next-state and registered-output logic. Outputs are computed for the
   // state being entered, so grants are visible right after the sampling edge.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lastOwner_d  = lastOwner_q;
      counter_d    = counter_q;
      m1Grant_d    = 1'b0;
      m2Grant_d    = 1'b0;
      busy_d       = 1'b0;
      busGrant_d   = 2'b00;
      slaveGrant_d = 2'b00;
      timeout_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (m1Eligible || m2Eligible) begin
               state_d      = HOLD;
               owner_d      = winnerM2;
               counter_d    = 16'd0;
               m1Grant_d    = !winnerM2;
               m2Grant_d    = winnerM2;
               busGrant_d   = winnerM2 ? 2'b10 : 2'b01;
               slaveGrant_d = winnerM2 ? m2_slave_select : m1_slave_select;
               busy_d       = 1'b1;
            end
         end

         HOLD: begin
            busy_d    = 1'b1;
            counter_d = counter_q + 16'd1;
            if (transaction_done) begin
               state_d = RELEASE;
            end else if (counter_q == TimeoutLast) begin
               state_d   = RELEASE;
               timeout_d = 1'b1;
            end else if (!ownerRequest) begin
               state_d = RELEASE;
            end else begin
               m1Grant_d    = m1Grant_q;
               m2Grant_d    = m2Grant_q;
               busGrant_d   = busGrant_q;
               slaveGrant_d = slaveGrant_q;
            end
         end

         RELEASE: begin
            state_d     = IDLE;
            lastOwner_d = owner_q;
            counter_d   = 16'd0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset leaves master 2 as last owner so that
   // master 1 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         lastOwner_q  <= 1'b1;
         counter_q    <= 16'd0;
         m1Grant_q    <= 1'b0;
         m2Grant_q    <= 1'b0;
         busy_q       <= 1'b0;
         busGrant_q   <= 2'b00;
         slaveGrant_q <= 2'b00;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         lastOwner_q  <= lastOwner_d;
         counter_q    <= counter_d;
         m1Grant_q    <= m1Grant_d;
         m2Grant_q    <= m2Grant_d;
         busy_q       <= busy_d;
         busGrant_q   <= busGrant_d;
         slaveGrant_q <= slaveGrant_d;
         timeout_q    <= timeout_d;
      end
   end

   assign m1_grant    = m1Grant_q;
   assign m2_grant    = m2Grant_q;
   assign busy        = busy_q;
   assign bus_grant   = busGrant_q;
   assign slave_grant = slaveGrant_q;
   assign timeout     = timeout_q;

endmodule
